// File: rtl/sdram_access_arbiter.sv
// SDRAM access arbiter: shares one controller port between bus disk read,
// bus disk write and the microSD engine, and issues periodic refresh.
// Fixed priority refresh > bus > microSD, non-preemptive.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access outstanding; pick the next requester
// REF   | ctl_refresh held, waiting for ctl_ack
// BUS   | bus read or write held on the controller, waiting for ctl_ack
// SD    | microSD access held on the controller, waiting for ctl_ack
module sdram_access_arbiter #(
  parameter int ADDR_W           = 21,
  parameter int DATA_W           = 16,
  parameter int REFRESH_INTERVAL = 312
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        cylinder,
  input  logic              head,
  input  logic [2:0]        sector,
  input  logic              load_address_busread,
  input  logic              dram_read_enbl_busread,
  input  logic              load_address_buswrite,
  input  logic              dram_write_enbl_buswrite,
  input  logic [DATA_W-1:0] bus_writedata,
  input  logic              sd_req,
  input  logic              sd_we,
  input  logic [ADDR_W-1:0] sd_addr,
  input  logic [DATA_W-1:0] sd_wdata,
  input  logic              ctl_ack,
  input  logic [DATA_W-1:0] ctl_rdata,
  output logic              ctl_req,
  output logic              ctl_we,
  output logic              ctl_refresh,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  output logic [DATA_W-1:0] dram_readdata,
  output logic              sd_ack,
  output logic [DATA_W-1:0] sd_rdata,
  output logic              overrun
);

  localparam int WORD_W = 9;
  localparam int REF_W  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_REF, S_BUS, S_SD} state_t;

  state_t              state, state_nxt;
  logic                grant_bus, grant_sd;
  logic                pend_rd, pend_wr, pend_ref;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   wdata_lat;
  logic                addr_reloaded;
  logic [REF_W-1:0]    ref_cnt;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_we;
  logic [DATA_W-1:0]   acc_wdata;

  logic                rd_pulse, load_any, bus_done, sd_done, ref_done;
  logic [ADDR_W-1:0]   load_val, acc_next;

  assign rd_pulse = load_address_busread | dram_read_enbl_busread;
  assign load_any = load_address_busread | load_address_buswrite;
  assign bus_done = (state == S_BUS) && ctl_ack;
  assign sd_done  = (state == S_SD)  && ctl_ack;
  assign ref_done = (state == S_REF) && ctl_ack;
  assign load_val = ADDR_W'({cylinder, head, sector, {WORD_W{1'b0}}});
  // Word field wraps inside the sector; sector/head/cylinder never carry.
  assign acc_next = {acc_addr[ADDR_W-1:WORD_W], acc_addr[WORD_W-1:0] + 9'd1};

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: priority pick in IDLE, otherwise hold until the controller acks.
  // sd_req is masked while sd_ack is high so the requester has a cycle to drop it.
  always_comb begin
    state_nxt = state;
    grant_bus = 1'b0;
    grant_sd  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_ref) begin
          state_nxt = S_REF;
        end else if (pend_rd || pend_wr) begin
          state_nxt = S_BUS;
          grant_bus = 1'b1;
        end else if (sd_req && !sd_ack) begin
          state_nxt = S_SD;
          grant_sd  = 1'b1;
        end
      end
      S_REF, S_BUS, S_SD: begin
        if (ctl_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Controller-side outputs decoded from registered state and access latch
  always_comb begin
    ctl_req     = (state == S_BUS) || (state == S_SD);
    ctl_refresh = (state == S_REF);
    ctl_we      = ctl_req & acc_we;
    ctl_addr    = ctl_req ? acc_addr  : '0;
    ctl_wdata   = ctl_req ? acc_wdata : '0;
  end

  // Access latch: freezes address/direction/data at grant so later bus
  // activity cannot disturb an in-flight access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_addr  <= '0;
      acc_we    <= 1'b0;
      acc_wdata <= '0;
    end else if (grant_bus) begin
      acc_addr  <= bus_addr;
      acc_we    <= pend_wr && !pend_rd;
      acc_wdata <= wdata_lat;
    end else if (grant_sd) begin
      acc_addr  <= sd_addr;
      acc_we    <= sd_we;
      acc_wdata <= sd_wdata;
    end
  end

  // Bus pending flags, write-data capture and sticky overrun
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_rd   <= 1'b0;
      pend_wr   <= 1'b0;
      wdata_lat <= '0;
      overrun   <= 1'b0;
    end else begin
      if ((rd_pulse && pend_rd) || (dram_write_enbl_buswrite && pend_wr))
        overrun <= 1'b1;

      if (rd_pulse && !pend_rd)
        pend_rd <= 1'b1;
      else if (bus_done && !acc_we)
        pend_rd <= 1'b0;

      if (dram_write_enbl_buswrite && !pend_wr) begin
        pend_wr   <= 1'b1;
        wdata_lat <= bus_writedata;
      end else if (bus_done && acc_we) begin
        pend_wr <= 1'b0;
      end
    end
  end

  // Bus address: load wins; otherwise post-increment after each bus access
  // unless a reload arrived while that access was in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_addr      <= '0;
      addr_reloaded <= 1'b0;
    end else begin
      if (load_any)
        bus_addr <= load_val;
      else if (bus_done && !addr_reloaded)
        bus_addr <= acc_next;

      if (grant_bus)
        addr_reloaded <= 1'b0;
      else if ((state == S_BUS) && load_any)
        addr_reloaded <= 1'b1;
    end
  end

  // Refresh timer; an expiry while a refresh is still pending merges into it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt  <= '0;
      pend_ref <= 1'b0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt  <= '0;
      pend_ref <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
      if (ref_done) pend_ref <= 1'b0;
    end
  end

  // Completion side: registered read data and the one-cycle microSD ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dram_readdata <= '0;
      sd_rdata      <= '0;
      sd_ack        <= 1'b0;
    end else begin
      sd_ack <= sd_done;
      if (bus_done && !acc_we) dram_readdata <= ctl_rdata;
      if (sd_done && !acc_we)  sd_rdata      <= ctl_rdata;
    end
  end

endmodule
